addr_stream_reader: RTL and testbench

Consumer end of the address-generator stream. Accepts byte-space addresses over a valid/ready handshake, issues word reads to a synchronous memory with 1-cycle read latency, and presents the returned words as a valid/ready data stream. Internal buffering absorbs memory latency under output backpressure, so throughput is one word per cycle. The block sits between an address generator and a datapath unit inside a memory-backed Versat unit.

---
 rtl/addr_stream_reader_pkg.sv | 10 +
 rtl/addr_stream_reader_fifo.sv | 42 ++++
 rtl/addr_stream_reader.sv | 81 ++++++++
 tb/tb_addr_stream_reader.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/addr_stream_reader_pkg.sv
// Shared Versat definitions.
// The generator and the reader both take the word-offset width from here.
package addr_stream_reader_pkg;

  // Number of byte-offset bits inside one memory word.
  function automatic int offset_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/addr_stream_reader_fifo.sv
// stream_fifo: synchronous FIFO with push/pop, occupancy and sync clear.
// Ports: clk, rst, clear, push, wdata, pop, rdata (head), occ (0..DEPTH).
module stream_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic [CW-1:0]     occ
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      occ <= occ + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset; pointers define what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/addr_stream_reader.sv
// addr_stream_reader: byte addresses in, memory words out, credit-based.
// Ports: addr_* input stream, mem_* read port (1-cycle latency),
//   data_* output stream, misaligned (sticky), done, run (flush), rst.
module addr_stream_reader
  import addr_stream_reader_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  localparam int OFFSET_W = offset_w(DATA_W)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       addr_valid,
  output logic                       addr_ready,
  input  logic [ADDR_W-1:0]          addr,
  input  logic                       addr_done,
  output logic                       mem_en,
  output logic [ADDR_W-OFFSET_W-1:0] mem_addr,
  input  logic [DATA_W-1:0]          mem_rdata,
  output logic                       data_valid,
  input  logic                       data_ready,
  output logic [DATA_W-1:0]          data,
  output logic                       misaligned,
  output logic                       done
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LOW_MASK =
    ADDR_W'((1 << OFFSET_W) - 1);

  logic [CW-1:0] occ;
  logic [CW:0]   credit;
  logic          inflight;
  logic          done_seen;
  logic          pop;
  logic          accept;

  assign data_valid = (occ != '0);
  assign pop        = data_valid && data_ready;

  // Slots committed next cycle; a pop this cycle frees one immediately.
  assign credit = {1'b0, occ} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign addr_ready = !run && (credit < (CW+1)'(DEPTH));
  assign accept     = addr_valid && addr_ready;
  assign mem_en     = accept;
  assign mem_addr   = addr[ADDR_W-1:OFFSET_W];

  always_ff @(posedge clk) begin
    if (rst || run) begin
      inflight   <= 1'b0;
      done_seen  <= 1'b0;
      misaligned <= 1'b0;
      done       <= 1'b0;
    end else begin
      inflight <= accept;
      if (addr_done) done_seen <= 1'b1;
      if (accept && |(addr & LOW_MASK)) misaligned <= 1'b1;
      if (done_seen && !inflight && occ == '0 && !accept)
        done <= 1'b1;
    end
  end

  // Clearing on run also drops the read returning in the next cycle,
  // because inflight is cleared alongside the buffer.
  stream_fifo #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clear(run),
    .push (inflight),
    .wdata(mem_rdata),
    .pop  (pop),
    .rdata(data),
    .occ  (occ)
  );

endmodule

// File: tb/tb_addr_stream_reader.sv
// Randomized bench for addr_stream_reader with a queue-based model.
// Memory returns word_address*3.
module tb_addr_stream_reader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              run;
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic              addr_done;
  logic              mem_en;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              data_valid;
  logic              data_ready;
  logic [DATA_W-1:0] data;
  logic              misaligned;
  logic              done;

  addr_stream_reader #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .addr      (addr),
    .addr_done (addr_done),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data      (data),
    .misaligned(misaligned),
    .done      (done)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Behavioural model state
  logic [31:0] m_buf[$];
  bit          m_infl = 0;
  logic [31:0] m_infl_val = 0;
  bit          m_done_seen = 0;
  bit          m_mis = 0;
  bit          m_done = 0;

  // Observation records
  logic [31:0] got[$];
  int          got_cyc[$];
  int          first_acc = -1;
  int          first_dv = -1;
  int          acc_cnt = 0;
  logic [31:0] rd_next = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: budget expired, got no progress expected completion (cycle %0d)",
             name, cyc);
  endtask

  // Compare process: check outputs, then advance the model one edge.
  always @(negedge clk) begin
    bit m_pop, m_ready, m_acc;
    cyc++;
    m_pop   = (m_buf.size() != 0) && data_ready;
    m_ready = !run &&
      (int'(m_buf.size()) + int'(m_infl) - int'(m_pop) < DEPTH);
    m_acc   = addr_valid && m_ready;
    chk("addr_ready", addr_ready, m_ready);
    chk("mem_en", mem_en, m_acc);
    if (m_acc) chk("mem_addr", mem_addr, addr >> 2);
    chk("data_valid", data_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) chk("data", data, m_buf[0]);
    chk("misaligned", misaligned, m_mis);
    chk("done", done, m_done);
    chk("occ_bound", dut.occ <= DEPTH, 1);

    if (data_valid && data_ready) begin
      got.push_back(data);
      got_cyc.push_back(cyc);
    end
    if (mem_en && first_acc < 0) first_acc = cyc;
    if (data_valid && first_dv < 0) first_dv = cyc;
    if (mem_en) acc_cnt++;
    rd_next = mem_en ? 32'(mem_addr) * 3 : $urandom;

    if (rst || run) begin
      m_buf.delete();
      m_infl = 0;
      m_done_seen = 0;
      m_mis = 0;
      m_done = 0;
    end else begin
      if (m_done_seen && !m_infl && m_buf.size() == 0 && !m_acc)
        m_done = 1;
      if (m_pop) void'(m_buf.pop_front());
      if (m_infl) m_buf.push_back(m_infl_val);
      m_infl = m_acc;
      m_infl_val = 32'(addr >> 2) * 3;
      if (m_acc && addr[1:0] != 2'b00) m_mis = 1;
      if (addr_done) m_done_seen = 1;
    end
  end

  // Synchronous memory: data for the previous cycle's read.
  always begin
    @(posedge clk);
    #1;
    mem_rdata = rd_next;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1;
    tick();
    run = 0;
  endtask

  task automatic clear_rec();
    got.delete();
    got_cyc.delete();
    first_acc = -1;
    first_dv = -1;
    acc_cnt = 0;
  endtask

  // rmode: 0 ready low, 1 ready high, 2 random (also random addrs/valid)
  task automatic drive_addrs(input int n, input int base,
                             input int stride, input int rmode);
    int i = 0;
    int guard = 0;
    bit acc;
    logic [ADDR_W-1:0] cur;
    cur = ADDR_W'(base);
    while (i < n && guard < 4000) begin
      if (rmode == 2) begin
        addr_valid = ($urandom_range(0, 3) != 0);
        data_ready = $urandom_range(0, 1);
      end else begin
        addr_valid = 1;
        data_ready = (rmode == 1);
      end
      addr = cur;
      addr_done = (i == n - 1);
      @(negedge clk);
      acc = addr_valid && addr_ready;
      tick();
      guard++;
      if (acc) begin
        i++;
        if (rmode == 2) begin
          cur = ADDR_W'($urandom_range(0, 1023));
          if ($urandom_range(0, 7) != 0) cur[1:0] = 2'b00;
        end else begin
          cur = ADDR_W'(base + i * stride);
        end
      end
    end
    if (i < n) timeout("drive_addrs");
    addr_valid = 0;
    addr_done = 0;
  endtask

  task automatic drain(input int rmode);
    int n = 0;
    addr_valid = 0;
    addr_done = 1;
    while (!m_done && n < 300) begin
      data_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      addr_done = 0;
      n++;
    end
    addr_done = 0;
    if (!m_done) timeout("drain");
    @(negedge clk);
    chk("done_after_drain", done, 1);
    tick();
  endtask

  initial begin
    rst = 1;
    run = 0;
    addr_valid = 0;
    addr = '0;
    addr_done = 0;
    data_ready = 0;
    mem_rdata = '0;
    repeat (3) tick();
    rst = 0;
    @(negedge clk);
    chk("rst_data_valid", data_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_misaligned", misaligned, 0);
    chk("rst_addr_ready", addr_ready, 1);
    tick();

    // Streaming: 0,4,...,28 back to back
    clear_rec();
    drive_addrs(8, 0, 4, 1);
    drain(1);
    chk("stream_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("stream_data", got[i], i * 3);
    chk("stream_latency", first_dv - first_acc, 2);
    if (got_cyc.size() == 8)
      chk("stream_no_bubble", got_cyc[7] - got_cyc[0], 7);

    // Backpressure: ready low for 10 cycles
    pulse_run();
    clear_rec();
    begin
      logic [ADDR_W-1:0] a;
      bit acc;
      a = 10'h40;
      data_ready = 0;
      for (int k = 0; k < 10; k++) begin
        addr_valid = 1;
        addr = a;
        @(negedge clk);
        acc = addr_ready;
        tick();
        if (acc) a = a + 10'd4;
      end
      @(negedge clk);
      chk("bp_ready_low", addr_ready, 0);
      tick();
      addr_valid = 0;
    end
    chk("bp_accepts", acc_cnt, 2);
    drain(1);
    chk("bp_count", got.size(), 2);
    if (got.size() == 2) begin
      chk("bp_word0", got[0], 48);
      chk("bp_word1", got[1], 51);
    end

    // Random ready over 200 addresses
    pulse_run();
    clear_rec();
    drive_addrs(200, 0, 0, 2);
    drain(2);
    chk("rand_count", got.size(), 200);

    // Misaligned address 6
    pulse_run();
    data_ready = 1;
    addr_valid = 1;
    addr = 10'd6;
    @(negedge clk);
    chk("mis_mem_addr", mem_addr, 1);
    tick();
    addr_valid = 0;
    repeat (3) tick();
    @(negedge clk);
    chk("mis_sticky", misaligned, 1);
    tick();
    drain(1);
    pulse_run();
    @(negedge clk);
    chk("mis_cleared", misaligned, 0);
    tick();

    // run mid-stream: one buffered, one inflight
    pulse_run();
    data_ready = 0;
    addr_valid = 1;
    addr = 10'h80;
    tick();
    addr = 10'h84;
    tick();
    run = 1;
    tick();
    run = 0;
    addr_valid = 0;
    @(negedge clk);
    chk("run_data_valid", data_valid, 0);
    chk("run_done", done, 0);
    tick();
    tick();
    @(negedge clk);
    chk("run_discard", data_valid, 0);
    tick();
    clear_rec();
    drive_addrs(8, 'h100, 4, 1);
    drain(1);
    chk("restart_count", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++)
      chk("restart_data", got[i], (64 + i) * 3);

    // rst mid-stream
    pulse_run();
    data_ready = 0;
    addr_valid = 1;
    addr = 10'd2;
    tick();
    addr = 10'd8;
    @(negedge clk);
    chk("pre_rst_mis", misaligned, 1);
    tick();
    rst = 1;
    tick();
    rst = 0;
    addr_valid = 0;
    @(negedge clk);
    chk("rst2_data_valid", data_valid, 0);
    chk("rst2_done", done, 0);
    chk("rst2_misaligned", misaligned, 0);
    chk("rst2_addr_ready", addr_ready, 1);
    chk("rst2_mem_en", mem_en, 0);
    tick();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
